phy_tx_serializer: RTL and testbench
====================================

Name: phy_tx_serializer

Overview:
- Transmit-side PHY stage sitting directly upstream of the receive deserializer.
- Accepts one byte per lane per byte period, with a valid flag per lane, and serializes both lanes MSB-first onto single-bit outputs at clk_8f.
- After reset it sends a training burst of comma bytes (0xBC) on both lanes so the receiver can align.
- Any invalid byte slot in normal operation is filled with a comma, so the receiver de-asserts its valid for that slot.

Parameters:
- COMMA, 8'hBC, idle/alignment byte inserted during training and for invalid slots.
- SYNC_BYTES, 4, number of comma bytes sent on both lanes after reset before data is accepted (legal range 1..15).

Ports:
- clk_8f  input  1  bit clock; one serial bit per lane per rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, serializer is frozen.
- data_in_0  input  8  lane 0 byte.
- valid_in_0  input  1  lane 0 byte valid.
- data_in_1  input  8  lane 1 byte.
- valid_in_1  input  1  lane 1 byte valid.
- out_0  output  1  lane 0 serial bit.
- out_1  output  1  lane 1 serial bit.
- byte_ready  output  1  data_in_x/valid_in_x are sampled on the rising edge ending this cycle.
- active  output  1  high once training is complete.

Behaviour:
- Reset (async, high):
  - state=SYNC, bit_cnt=7, sync_cnt=0, both shift registers=0.
  - out_0=out_1=0, byte_ready=0, active=0.
  - Asserting reset mid-byte aborts that byte immediately. Training restarts on the first enabled edge after release.
- bit_cnt (3 bits): increments modulo 8 on each enabled edge. A load edge is an enabled edge with bit_cnt==7.
- Shift registers:
  - On a load edge, shift_x <= next byte.
  - On other enabled edges, shift_x <= shift_x<<1.
  - out_x = enable ? shift_x[7] : 0, i.e. MSB first.
  - A byte loaded at edge E shows its bit 7 after E and its bit 0 after E+7.
- State SYNC:
  - Next byte = COMMA on both lanes; inputs are ignored.
  - On each load edge, sync_cnt increments.
  - On the load edge where sync_cnt==SYNC_BYTES-1, that final comma is loaded and state becomes ACTIVE.
- State ACTIVE:
  - Per lane independently, next byte = valid_in_x ? data_in_x : COMMA.
  - There is no data-value check: a valid 8'hBC is sent as-is and is indistinguishable on the line.
- byte_ready (combinational) = enable && state==ACTIVE && bit_cnt==7.
  - With continuous enable, it is a one-cycle pulse every 8 cycles.
  - The upstream source must hold data/valid stable across that cycle.
- active = (state==ACTIVE), registered.
- enable low:
  - bit_cnt, sync_cnt, state and shift registers hold.
  - out_x=0, byte_ready=0.
  - Resuming continues the interrupted byte from the held bit position. No byte is duplicated or dropped.
- Simultaneous events: reset dominates enable and load. enable low on a would-be load edge means no load and no sample.
- Line timing: the first comma bit appears after the first enabled edge following reset release. The first data byte is loaded at enabled edge number 8*SYNC_BYTES+1.

Test Plan:
- Reset, then enable=1 with SYNC_BYTES=4 -> each lane outputs 10111100 four times (32 bits). active rises after edge 25. byte_ready first pulses in the cycle before edge 33.
- ACTIVE, lane0 0xFF/valid, lane1 0x00/valid -> out_0 = eight 1s, out_1 = eight 0s, starting right after the load edge.
- ACTIVE, lane0 0x99 valid, lane1 0x11 valid; next byte lane0 0xEE valid, lane1 valid=0 -> out_0 10011001 then 11101110; out_1 00010001 then 10111100.
- Drop enable for 3 cycles after bit 3 of a 0xDD byte -> out_x=0 during the gap, then 1101 resumes. byte_ready spacing stretches to 11 cycles.
- Assert reset at bit 5 of a data byte -> outputs go 0 immediately, active=0. After release, four full commas precede any data, and no partial byte is emitted.
- Continuous valid 0xAA on both lanes for 4 bytes -> 32 alternating bits 1010..., with byte_ready pulsing exactly every 8 cycles.

Source files
------------

// File: rtl/phy_tx_serializer.sv
// Two-lane transmit serializer: sends a comma training burst after reset, then
// shifts each lane's byte out MSB-first, substituting a comma for invalid slots.
module phy_tx_serializer #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned SYNC_BYTES = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] data_in_0,
    input  logic       valid_in_0,
    input  logic [7:0] data_in_1,
    input  logic       valid_in_1,
    output logic       out_0,
    output logic       out_1,
    output logic       byte_ready,
    output logic       active
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SYNC_W = 4;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(BYTE_W - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_BYTES - 1);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;
    logic [BYTE_W-1:0]   shift_0_q,  shift_0_d;
    logic [BYTE_W-1:0]   shift_1_q,  shift_1_d;
    logic                active_q,   active_d;
    logic                load_c;

    assign load_c = enable && (bit_cnt_q == LAST_BIT);

    // State, counters and shift registers
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SYNC;
            bit_cnt_q  <= LAST_BIT;
            sync_cnt_q <= '0;
            shift_0_q  <= '0;
            shift_1_q  <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            shift_0_q  <= shift_0_d;
            shift_1_q  <= shift_1_d;
            active_q   <= active_d;
        end
    end

    // Next-state: hold when disabled, load on the last bit, otherwise shift left
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        shift_0_d  = shift_0_q;
        shift_1_d  = shift_1_q;

        if (enable) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (load_c) begin
                case (state_q)
                    ST_SYNC: begin
                        shift_0_d  = COMMA;
                        shift_1_d  = COMMA;
                        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                        if (sync_cnt_q == SYNC_LAST) begin
                            state_d = ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        shift_0_d = valid_in_0 ? data_in_0 : COMMA;
                        shift_1_d = valid_in_1 ? data_in_1 : COMMA;
                    end
                    default: begin
                        state_d = ST_SYNC;
                    end
                endcase
            end else begin
                shift_0_d = {shift_0_q[BYTE_W-2:0], 1'b0};
                shift_1_d = {shift_1_q[BYTE_W-2:0], 1'b0};
            end
        end

        // Tracks the state being entered so active rises with the final training load
        active_d = (state_d == ST_ACTIVE);
    end

    assign out_0      = enable && shift_0_q[BYTE_W-1];
    assign out_1      = enable && shift_1_q[BYTE_W-1];
    assign byte_ready = load_c && (state_q == ST_ACTIVE);
    assign active     = active_q;

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Randomized bench for phy_tx_serializer, checked every cycle against a model
// that derives each line bit from the count of enabled edges since reset.
module tb_phy_tx_serializer;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int         SB    = 4;

    logic       clk_8f = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] data_in_0;
    logic       valid_in_0;
    logic [7:0] data_in_1;
    logic       valid_in_1;
    logic       out_0;
    logic       out_1;
    logic       byte_ready;
    logic       active;

    always #5 clk_8f = ~clk_8f;

    phy_tx_serializer #(
        .COMMA      (COMMA),
        .SYNC_BYTES (SB)
    ) dut (
        .clk_8f     (clk_8f),
        .reset      (reset),
        .enable     (enable),
        .data_in_0  (data_in_0),
        .valid_in_0 (valid_in_0),
        .data_in_1  (data_in_1),
        .valid_in_1 (valid_in_1),
        .out_0      (out_0),
        .out_1      (out_1),
        .byte_ready (byte_ready),
        .active     (active)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: enabled edges since reset and the bytes currently on the line
    int         edges;
    logic [7:0] cur_0;
    logic [7:0] cur_1;
    int         rst_hold;

    logic [7:0] pat_0 [8];
    logic [7:0] pat_1 [8];
    logic [7:0] vpat_0;
    logic [7:0] vpat_1;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t (edges=%0d)", tag, got, exp, $time, edges);
        end
    endtask

    function automatic logic [7:0] byte_for(input int idx, input logic v, input logic [7:0] d);
        if (idx < SB) return COMMA;
        return v ? d : COMMA;
    endfunction

    initial begin
        logic [2:0] bp;
        logic [2:0] pi;
        logic       e_out_0;
        logic       e_out_1;
        logic       e_br;
        logic       e_act;
        int         k;

        pat_0  = '{8'hFF, 8'h99, 8'hEE, 8'hAA, 8'hAA, 8'hBC, 8'hDD, 8'h5A};
        pat_1  = '{8'h00, 8'h11, 8'h00, 8'hAA, 8'hAA, 8'h3C, 8'hDD, 8'hBC};
        vpat_0 = 8'b1111_1111;
        vpat_1 = 8'b1111_1011;

        reset      = 1'b1;
        enable     = 1'b0;
        data_in_0  = 8'h00;
        data_in_1  = 8'h00;
        valid_in_0 = 1'b0;
        valid_in_1 = 1'b0;
        edges      = 0;
        cur_0      = 8'h00;
        cur_1      = 8'h00;
        rst_hold   = 3;

        for (int ph = 0; ph < 4; ph++) begin
            if (ph == 1 || ph == 2) rst_hold = 2;
            for (int c = 0; c < 320; c++) begin
                @(negedge clk_8f);

                if (rst_hold > 0) begin
                    reset = 1'b1;
                    rst_hold--;
                end else if (ph == 3 && $urandom_range(0, 59) == 0) begin
                    reset    = 1'b1;
                    rst_hold = $urandom_range(0, 2);
                end else begin
                    reset = 1'b0;
                end
                if (reset) edges = 0;

                pi = 3'((edges / 8) % 8);
                case (ph)
                    0: begin
                        enable     = 1'b1;
                        data_in_0  = 8'($urandom);
                        data_in_1  = 8'($urandom);
                        valid_in_0 = 1'b1;
                        valid_in_1 = 1'b1;
                    end
                    2: begin
                        enable     = (c % 29) >= 3;
                        data_in_0  = pat_0[pi];
                        data_in_1  = pat_1[pi];
                        valid_in_0 = vpat_0[pi];
                        valid_in_1 = vpat_1[pi];
                    end
                    default: begin
                        enable     = $urandom_range(0, 9) < ((ph == 1) ? 7 : 8);
                        data_in_0  = 8'($urandom);
                        data_in_1  = 8'($urandom);
                        valid_in_0 = 1'($urandom);
                        valid_in_1 = 1'($urandom);
                    end
                endcase

                #1;
                if (edges == 0) begin
                    e_out_0 = 1'b0;
                    e_out_1 = 1'b0;
                end else begin
                    bp      = 3'(7 - ((edges - 1) % 8));
                    e_out_0 = enable && cur_0[bp];
                    e_out_1 = enable && cur_1[bp];
                end
                e_br  = enable && !reset && (edges % 8 == 0) && (edges / 8 >= SB);
                e_act = edges >= 8 * (SB - 1) + 1;

                check_eq("out_0",      8'(out_0),      8'(e_out_0));
                check_eq("out_1",      8'(out_1),      8'(e_out_1));
                check_eq("byte_ready", 8'(byte_ready), 8'(e_br));
                check_eq("active",     8'(active),     8'(e_act));

                @(posedge clk_8f);
                if (!reset && enable) begin
                    edges++;
                    if ((edges - 1) % 8 == 0) begin
                        k     = (edges - 1) / 8;
                        cur_0 = byte_for(k, valid_in_0, data_in_0);
                        cur_1 = byte_for(k, valid_in_1, data_in_1);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
